// File: rtl/spi_frame_rx.sv
// ---------------------------------------------------------------------------
// spi_frame_rx
//
// SPI mode-0 frame receiver. It brings the raw SCLK/COPI/nCS pins into the
// system clock domain, deserialises MSB-first frames of
// 1 + ADDR_W + DATA_W bits (R/W flag, address, data) and issues a
// one-cycle write strobe with address and data for every complete write
// frame. Frames that end with the wrong bit count raise a one-cycle
// frame_err pulse instead. Frames that end with the right count but R/W = 0
// (reads) are dropped silently.
//
// Parameters:
//   SYNC_STAGES  depth of each input synchroniser (>= 2)
//   ADDR_W       address field width
//   DATA_W       data field width
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   sclk       raw SPI clock pin (asynchronous)
//   copi       raw SPI data pin (asynchronous)
//   ncs        raw active-low chip select pin (asynchronous)
//   wr_valid   one-cycle pulse: wr_addr/wr_data hold a new write
//   wr_addr    address of the last accepted write
//   wr_data    data of the last accepted write
//   frame_err  one-cycle pulse: frame ended with a bad bit count
//   busy       high while a frame is being shifted in
// ---------------------------------------------------------------------------
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
    // One extra count value beyond FRAME_BITS marks a long frame, so the
    // counter must reach FRAME_BITS + 1 without wrapping.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] copiSync_q;
    logic [SYNC_STAGES-1:0] ncsSync_q;
    logic                   sclkPrev_q;
    logic                   ncsPrev_q;

    logic                   sclkS;
    logic                   copiS;
    logic                   ncsS;
    logic                   sclkRise;
    logic                   ncsFall;
    logic                   ncsRise;

    logic [1:0]             state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   wrValid_q, wrValid_d;
    logic                   frameErr_q, frameErr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;

    // Synchronisers reset to the idle bus levels (ncs high, sclk/copi low)
    // so that leaving reset never looks like an edge. New samples enter at
    // bit 0 and the synchronised value is taken from the top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclkSync_q <= '0;
            copiSync_q <= '0;
            ncsSync_q  <= '1;
            sclkPrev_q <= 1'b0;
            ncsPrev_q  <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
            copiSync_q <= {copiSync_q[SYNC_STAGES-2:0], copi};
            ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], ncs};
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            ncsPrev_q  <= ncsSync_q[SYNC_STAGES-1];
        end
    end

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign copiS    = copiSync_q[SYNC_STAGES-1];
    assign ncsS     = ncsSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign ncsFall  = ~ncsS & ncsPrev_q;
    assign ncsRise  = ncsS & ~ncsPrev_q;

    // Frame FSM. IDLE also starts a frame on a level-low ncs so that a
    // select that falls while END is active is not lost. An sclk rise in
    // the same cycle that a frame starts is shifted in immediately, since
    // the shift qualifier is "sync ncs low", not the edge itself.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        wrValid_d  = 1'b0;
        frameErr_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                count_d = '0;
                if (ncsFall || !ncsS) begin
                    state_d = ST_SHIFT;
                    if (sclkRise) begin
                        shift_d = {{(FRAME_BITS-1){1'b0}}, copiS};
                        count_d = CNT_W'(1);
                    end
                end
            end

            ST_SHIFT: begin
                if (ncsRise) begin
                    state_d = ST_END;
                end else if (sclkRise && !ncsS) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copiS};
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
                if (count_q == CNT_FULL) begin
                    if (shift_q[FRAME_BITS-1]) begin
                        wrValid_d = 1'b1;
                        addr_d    = shift_q[FRAME_BITS-2 -: ADDR_W];
                        data_d    = shift_q[DATA_W-1:0];
                    end
                end else begin
                    frameErr_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; the strobes and the write fields are
    // registered out of END so they appear together one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            wrValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            wrValid_q  <= wrValid_d;
            frameErr_q <= frameErr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign wr_valid  = wrValid_q;
    assign frame_err = frameErr_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_rx
//
// Directed bench for spi_frame_rx at default parameters. Drives SPI frames
// bit by bit on the falling system clock edge, logs every wr_valid /
// frame_err cycle seen on the falling edge, and compares against
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_spi_frame_rx;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       busy;

    int checks;
    int errors;

    // Event log filled by the monitor, read as deltas by the main sequence
    int          validCycles;
    int          errCycles;
    int          bothCycles;
    logic [31:0] wrLog[$];
    int          lastLatency;

    int vBase;
    int eBase;
    int qBase;

    spi_frame_rx #(
        .SYNC_STAGES(2),
        .ADDR_W(7),
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .copi(copi),
        .ncs(ncs),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_err(frame_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor sampling away from the active edge
    initial begin
        validCycles = 0;
        errCycles   = 0;
        bothCycles  = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                validCycles = validCycles + 1;
                wrLog.push_back(32'({wr_addr, wr_data}));
            end
            if (frame_err) errCycles = errCycles + 1;
            if (wr_valid && frame_err) bothCycles = bothCycles + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic snapshot();
        vBase = validCycles;
        eBase = errCycles;
        qBase = wrLog.size();
    endtask

    // Send nbits of frame MSB first, raise ncs, then hold ncs high for gap
    // cycles while recording how many clk edges until wr_valid appears.
    task automatic applyStimulus(input logic [31:0] frame, input int nbits, input int gap);
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = frame[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        lastLatency = 0;
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk);
            if (wr_valid && lastLatency == 0) lastLatency = i;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_addr_data", 32'({wr_addr, wr_data}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single write 0x8055, also measuring ncs-rise to wr_valid latency
        snapshot();
        applyStimulus(32'h8055, 16, 12);
        checkOutput("w1_valid_cycles", 32'(validCycles - vBase), 32'd1);
        checkOutput("w1_err_cycles", 32'(errCycles - eBase), 32'd0);
        checkOutput("w1_latency", 32'(lastLatency), 32'd4);
        checkOutput("w1_addr", 32'(wr_addr), 32'h00);
        checkOutput("w1_data", 32'(wr_data), 32'h55);

        // Back-to-back writes with a 3-cycle ncs gap
        snapshot();
        applyStimulus(32'h81F0, 16, 3);
        applyStimulus(32'h840F, 16, 12);
        checkOutput("b2b_valid_cycles", 32'(validCycles - vBase), 32'd2);
        checkOutput("b2b_err_cycles", 32'(errCycles - eBase), 32'd0);
        if (wrLog.size() >= qBase + 2) begin
            checkOutput("b2b_first", wrLog[qBase], {17'd0, 7'h01, 8'hF0});
            checkOutput("b2b_second", wrLog[qBase + 1], {17'd0, 7'h04, 8'h0F});
        end else begin
            checkOutput("b2b_log_size", 32'(wrLog.size() - qBase), 32'd2);
        end

        // Read frame is dropped silently
        snapshot();
        applyStimulus(32'h0312, 16, 12);
        checkOutput("rd_valid_cycles", 32'(validCycles - vBase), 32'd0);
        checkOutput("rd_err_cycles", 32'(errCycles - eBase), 32'd0);
        checkOutput("rd_addr_data", 32'({wr_addr, wr_data}), {17'd0, 7'h04, 8'h0F});

        // Short frame (15 bits) then long frame (17 bits)
        snapshot();
        applyStimulus(32'h40AA, 15, 12);
        checkOutput("short_err_cycles", 32'(errCycles - eBase), 32'd1);
        applyStimulus(32'h1_0155, 17, 12);
        checkOutput("long_err_cycles", 32'(errCycles - eBase), 32'd2);
        checkOutput("badlen_valid_cycles", 32'(validCycles - vBase), 32'd0);
        checkOutput("badlen_addr_data", 32'({wr_addr, wr_data}), {17'd0, 7'h04, 8'h0F});

        // Idle sclk toggles with ncs high must not disturb the next frame
        snapshot();
        for (int i = 0; i < 20; i++) begin
            copi = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        checkOutput("idle_busy", 32'(busy), 32'd0);
        applyStimulus(32'h82AA, 16, 12);
        checkOutput("idle_valid_cycles", 32'(validCycles - vBase), 32'd1);
        checkOutput("idle_err_cycles", 32'(errCycles - eBase), 32'd0);
        checkOutput("idle_addr_data", 32'({wr_addr, wr_data}), {17'd0, 7'h02, 8'hAA});

        // Reset in the middle of 0x80FF after 8 bits
        snapshot();
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 15; i >= 8; i--) begin
            copi = (i == 15) ? 1'b1 : 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        rst  = 1'b1;
        ncs  = 1'b1;
        copi = 1'b0;
        #1;
        checkOutput("abort_reset_outputs",
                    32'({wr_valid, frame_err, busy, wr_addr, wr_data}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("abort_no_strobe", 32'((validCycles - vBase) + (errCycles - eBase)), 32'd0);
        checkOutput("abort_addr_data", 32'({wr_addr, wr_data}), 32'd0);

        snapshot();
        applyStimulus(32'h8133, 16, 12);
        checkOutput("post_valid_cycles", 32'(validCycles - vBase), 32'd1);
        checkOutput("post_err_cycles", 32'(errCycles - eBase), 32'd0);
        checkOutput("post_addr_data", 32'({wr_addr, wr_data}), {17'd0, 7'h01, 8'h33});

        checkOutput("never_both_strobes", 32'(bothCycles), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

SPI-mode-0 frame receiver sitting between the chip input pins (SCLK, COPI, nCS on ui_in[0..2]) and the register bank that holds the output-enable, PWM-enable and duty-cycle registers. It synchronises the raw pins into the system clock domain and detects edges. It deserialises 16-bit MSB-first frames and emits a one-cycle write strobe with address and data for every complete write frame. Malformed frames are flagged and never produce a write.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser (legal ≥2).
- ADDR_W, 7: address field width.
- DATA_W, 8: data field width. Frame length FRAME_BITS = 1 + ADDR_W + DATA_W (16 at defaults).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  raw SPI clock pin, asynchronous to clk.
- copi  in  1  raw SPI data pin, asynchronous.
- ncs  in  1  raw chip select, active low, asynchronous.
- wr_valid  out  1  one-cycle pulse: wr_addr/wr_data hold a new write.
- wr_addr  out  ADDR_W  address of last accepted write.
- wr_data  out  DATA_W  data of last accepted write.
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ FRAME_BITS.
- busy  out  1  high while in SHIFT state.

## Operation
- Each of sclk/copi/ncs passes through its own SYNC_STAGES-deep synchroniser. A further register holds the previous synchronised sclk/ncs for edge detection.
- sclk_rise = sync sclk 1 and previous 0. ncs_fall / ncs_rise defined likewise.
- Frame format, MSB first: bit[FRAME_BITS-1] = R/W (1 = write), next ADDR_W bits = address, last DATA_W bits = data.
- FSM states:
  - IDLE: shift register and bit counter cleared. ncs_fall → SHIFT.
  - SHIFT: on sclk_rise with sync ncs low, shift sync copi into the LSB and increment the counter. The counter saturates at FRAME_BITS+1. ncs_rise → END.
  - END: one cycle, then → IDLE. Outputs evaluated here:
    - count == FRAME_BITS and R/W = 1: wr_valid = 1, and wr_addr/wr_data are loaded.
    - count == FRAME_BITS and R/W = 0: read frame, silently dropped. No wr_valid, no frame_err.
    - count ≠ FRAME_BITS (short, long, or zero bits): frame_err = 1. wr_addr/wr_data are unchanged.
- sclk_rise detected in the same cycle as ncs_fall is counted, because the shift condition uses sync ncs low. sclk_rise in the same cycle as ncs_rise is not counted.
- sclk activity while sync ncs is high is ignored in all states.
- A new ncs_fall during END is not lost. END always lasts one cycle, and IDLE then sees sync ncs low. IDLE therefore also enters SHIFT when sync ncs is low without an edge, as long as the previous frame has ended.
- wr_valid and frame_err are mutually exclusive.

## Timing
- Reset values: wr_valid 0, frame_err 0, busy 0, wr_addr 0, wr_data 0, FSM IDLE, all synchroniser flops 1 for ncs and 0 for sclk/copi (idle bus).
- rst is asserted asynchronously and released synchronously by the caller. Reset mid-frame discards the partial frame with no strobe and no error.
- Latency: raw ncs rising edge (meeting setup) → wr_valid high after SYNC_STAGES+2 clk edges. wr_addr/wr_data become valid in that same cycle.
- wr_addr/wr_data are held until the next accepted write. The consumer may sample them on any cycle with wr_valid high; there is no back-pressure.
- busy rises 1 cycle after sync ncs falls and drops on entry to END.
- Supported SPI rate: sclk high and low phases each ≥ SYNC_STAGES+1 clk periods. copi must be stable across the sync sclk rise. ncs high time ≥ 3 clk periods.

## Test plan
- Write frame 0x8055 (addr 0x00, data 0x55): wr_valid exactly one cycle, wr_addr = 0x00, wr_data = 0x55, frame_err never high.
- Back-to-back writes 0x81F0 then 0x840F with minimum ncs gap: two wr_valid pulses, with (0x01, 0xF0) then (0x04, 0x0F).
- Read frame 0x0312: no wr_valid, no frame_err, and wr_addr/wr_data keep their previous values.
- Short frame of 15 bits, then long frame of 17 bits: frame_err pulses once each, no wr_valid, outputs unchanged.
- Toggle sclk 20 times with ncs high, then send 0x82AA: only one write (0x02, 0xAA), and the counter is unaffected by the idle clocks.
- Assert rst after 8 bits of 0x80FF, release, then send 0x8133: no strobe from the aborted frame, all outputs 0 after reset, then a single write (0x01, 0x33).
